// File: rtl/interrupt_sequencer_if.sv
// interrupt_sequencer_if: request pins, core state inputs and bus/strobe outputs of the sequencer
interface interrupt_sequencer_if #(
  parameter int N_CHAN     = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  localparam int CW = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
  logic [N_CHAN-1:0]     req_n;
  logic                  i_flag;
  logic                  instr_boundary;
  logic                  rdy;
  logic [ADDR_WIDTH-1:0] pc_in;
  logic [DATA_WIDTH-1:0] sp_in;
  logic [DATA_WIDTH-1:0] status_in;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  busy;
  logic [CW-1:0]         active_chan;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic                  bus_we;
  logic                  bus_req;
  logic [ADDR_WIDTH-1:0] pc_out;
  logic                  pc_we;
  logic [DATA_WIDTH-1:0] sp_out;
  logic                  sp_we;
  logic                  set_i;
  modport master (
    input  req_n, i_flag, instr_boundary, rdy, pc_in, sp_in, status_in, rdata,
    output busy, active_chan, bus_addr, bus_wdata, bus_we, bus_req, pc_out, pc_we, sp_out, sp_we, set_i
  );
  modport slave (
    output req_n, i_flag, instr_boundary, rdy, pc_in, sp_in, status_in, rdata,
    input  busy, active_chan, bus_addr, bus_wdata, bus_we, bus_req, pc_out, pc_we, sp_out, sp_we, set_i
  );
endinterface

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: prioritised interrupt/reset entry sequencer (push PC/P, fetch vector, load PC/SP)
module interrupt_sequencer #(
  parameter int                    N_CHAN     = 4,
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] VEC_BASE   = 16'hFFF8,
  parameter logic [ADDR_WIDTH-1:0] STACK_BASE = 16'h0100,
  parameter logic [N_CHAN-1:0]     EDGE_MASK  = 4'b0010,
  parameter logic [N_CHAN-1:0]     MASKABLE   = 4'b1000,
  parameter logic [N_CHAN-1:0]     PUSH_MASK  = 4'b1011
) (
  input logic clk,
  input logic reset,
  interrupt_sequencer_if.master bus
);
  localparam int CW = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] PUSH_H   = 3'd1;
  localparam logic [2:0] PUSH_L   = 3'd2;
  localparam logic [2:0] PUSH_P   = 3'd3;
  localparam logic [2:0] FETCH_LO = 3'd4;
  localparam logic [2:0] FETCH_HI = 3'd5;
  localparam logic [2:0] LOAD     = 3'd6;
  logic [2:0]            state, state_n;
  logic [N_CHAN-1:0]     latch, prev, pending, edges, clr;
  logic [CW-1:0]         chan, win;
  logic [DATA_WIDTH-1:0] sp, p_snap, vec_lo, vec_hi;
  logic [ADDR_WIDTH-1:0] pc_snap;
  logic                  sel, push_st, fetch_st, load_go;
  assign edges    = EDGE_MASK & prev & ~bus.req_n;
  assign pending  = ((EDGE_MASK & latch) | (~EDGE_MASK & ~bus.req_n)) & ~(MASKABLE & {N_CHAN{bus.i_flag}});
  assign sel      = (state == IDLE) && bus.instr_boundary && bus.rdy && |pending;
  assign clr      = sel ? {{(N_CHAN-1){1'b0}}, 1'b1} << win : '0;
  assign push_st  = (state == PUSH_H) || (state == PUSH_L) || (state == PUSH_P);
  assign fetch_st = (state == FETCH_LO) || (state == FETCH_HI);
  assign load_go  = (state == LOAD) && bus.rdy;
  // lowest-index pending channel wins
  always_comb begin
    win = '0;
    for (int i = N_CHAN-1; i >= 0; i--) if (pending[i]) win = CW'(i);
  end
  // sequence advances one state per ready cycle; PUSH_P+1 is FETCH_LO and FETCH_HI+1 is LOAD
  always_comb begin
    state_n = !bus.rdy ? state :
              (state == IDLE) ? (sel ? (PUSH_MASK[win] ? PUSH_H : FETCH_LO) : IDLE) :
              (state == LOAD) ? IDLE : state + 3'd1;
  end
  // state, edge latches, snapshots taken at selection, stack pointer walk and vector capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      latch   <= '0;
      prev    <= '0;
      chan    <= '0;
      sp      <= '0;
      pc_snap <= '0;
      p_snap  <= '0;
      vec_lo  <= '0;
      vec_hi  <= '0;
    end else begin
      prev  <= bus.req_n;
      latch <= (latch & ~clr) | edges;
      state <= state_n;
      if (sel) begin
        chan    <= win;
        sp      <= bus.sp_in;
        pc_snap <= bus.pc_in;
        p_snap  <= bus.status_in;
      end
      if (bus.rdy && push_st) sp <= sp - DATA_WIDTH'(1);
      if (bus.rdy && state == FETCH_LO) vec_lo <= bus.rdata;
      if (bus.rdy && state == FETCH_HI) vec_hi <= bus.rdata;
    end
  end
  assign bus.busy        = state != IDLE;
  assign bus.active_chan = chan;
  assign bus.bus_req     = push_st || fetch_st;
  assign bus.bus_we      = push_st;
  assign bus.bus_addr    = push_st  ? STACK_BASE + ADDR_WIDTH'(sp) :
                           fetch_st ? VEC_BASE + ADDR_WIDTH'({chan, 1'b0}) + ADDR_WIDTH'(state == FETCH_HI) : '0;
  assign bus.bus_wdata   = (state == PUSH_H) ? pc_snap[ADDR_WIDTH-1 -: DATA_WIDTH] :
                           (state == PUSH_L) ? pc_snap[DATA_WIDTH-1:0] :
                           (state == PUSH_P) ? (p_snap & ~DATA_WIDTH'(16)) | DATA_WIDTH'(32) : '0;
  assign bus.pc_out      = ADDR_WIDTH'({vec_hi, vec_lo});
  assign bus.pc_we       = load_go;
  assign bus.set_i       = load_go;
  assign bus.sp_we       = load_go && PUSH_MASK[chan];
  assign bus.sp_out      = sp;
endmodule
